// File: rtl/rr_arb_requester.sv
// rr_arb_requester
//   Requester-side companion to a 4-way round-robin, fixed-time-slice arbiter.
//   Each client hands over jobs of job_len beats. The block raises REQ[i] and
//   keeps it high until every beat of the job has been granted. If the arbiter
//   withdraws GNT[i] partway through a job (slice expiry), REQ[i] stays high and
//   the job resumes on the next grant. Each transferred beat is reported on beat,
//   and each finished job produces a one-cycle pulse on done.
//
//   Per client there is one ACTIVE slot (the job being transferred, with its
//   remaining-beat counter) and one PENDING slot (the next job, queued behind it).
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous reset, active-low
//   job_valid  [N]        client i offers a job
//   job_len    [N*LEN_W]  job length of client i in bits [i*LEN_W +: LEN_W]
//   job_ready  [N]        client i can accept a job (pending slot free)
//   REQ        [N]        registered request to the arbiter
//   GNT        [N]        grant from the arbiter
//   beat       [N]        combinational: beat transferred for client i this cycle
//   done       [N]        registered one-cycle pulse: client i job finished
//   err_multi             sticky: GNT seen with more than one bit set
//   err_spur              sticky: GNT[i] seen while REQ[i] was low
//
// Per-client FSM
//   state         | meaning
//   ST_IDLE       | no job with beats outstanding, REQ low
//   ST_REQUESTING | job outstanding, REQ high, waiting for (or re-waiting for) GNT
//   ST_GRANTED    | job outstanding, REQ high, a beat moved last cycle
module rr_arb_requester #(
    parameter int N     = 4,
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       job_valid,
    input  logic [N*LEN_W-1:0] job_len,
    output logic [N-1:0]       job_ready,
    output logic [N-1:0]       REQ,
    input  logic [N-1:0]       GNT,
    output logic [N-1:0]       beat,
    output logic [N-1:0]       done,
    output logic               err_multi,
    output logic               err_spur
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQUESTING = 2'd1,
        ST_GRANTED    = 2'd2
    } state_t;

    state_t           st_q   [N];
    state_t           st_n   [N];
    logic [LEN_W-1:0] rem_q  [N];
    logic [LEN_W-1:0] rem_n  [N];
    logic [LEN_W-1:0] plen_q [N];
    logic [LEN_W-1:0] plen_n [N];
    logic [N-1:0]     act_q, act_n;
    logic [N-1:0]     pend_q, pend_n;
    logic [N-1:0]     done_n;
    logic [N-1:0]     finish;
    logic [N-1:0]     accept;
    logic             gnt_multi;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign gnt_multi = (GNT & (GNT - N'(1))) != '0;

    assign job_ready = ~pend_q;
    assign beat      = REQ & GNT & {N{~gnt_multi}};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            REQ[i] = (st_q[i] != ST_IDLE);
        end
    end

    always_comb begin
        finish = '0;
        accept = '0;
        done_n = '0;
        act_n  = act_q;
        pend_n = pend_q;
        for (int i = 0; i < N; i++) begin
            rem_n[i]  = rem_q[i];
            plen_n[i] = plen_q[i];
            st_n[i]   = st_q[i];

            // A zero-length job sits in ACTIVE for one cycle and then finishes
            // without ever requesting, so it still gets its own done pulse.
            finish[i] = act_q[i] & ((beat[i] & (rem_q[i] == LEN_W'(1))) |
                                    (rem_q[i] == '0));
            accept[i] = job_valid[i] & ~pend_q[i];

            if (finish[i]) begin
                done_n[i] = 1'b1;
                if (pend_q[i]) begin
                    act_n[i]  = 1'b1;
                    rem_n[i]  = plen_q[i];
                    pend_n[i] = 1'b0;
                end else if (accept[i]) begin
                    // ACTIVE empties on this edge, so the new job skips PENDING.
                    act_n[i] = 1'b1;
                    rem_n[i] = job_len[i*LEN_W +: LEN_W];
                end else begin
                    act_n[i] = 1'b0;
                    rem_n[i] = '0;
                end
            end else begin
                if (beat[i]) begin
                    rem_n[i] = rem_q[i] - LEN_W'(1);
                end
                if (accept[i]) begin
                    if (!act_q[i]) begin
                        act_n[i] = 1'b1;
                        rem_n[i] = job_len[i*LEN_W +: LEN_W];
                    end else begin
                        pend_n[i] = 1'b1;
                        plen_n[i] = job_len[i*LEN_W +: LEN_W];
                    end
                end
            end

            if (!(act_n[i] && (rem_n[i] != '0))) begin
                st_n[i] = ST_IDLE;
            end else if (beat[i] && !finish[i]) begin
                st_n[i] = ST_GRANTED;
            end else begin
                st_n[i] = ST_REQUESTING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                st_q[i]   <= ST_IDLE;
                rem_q[i]  <= '0;
                plen_q[i] <= '0;
            end
            act_q     <= '0;
            pend_q    <= '0;
            done      <= '0;
            err_multi <= 1'b0;
            err_spur  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                st_q[i]   <= st_n[i];
                rem_q[i]  <= rem_n[i];
                plen_q[i] <= plen_n[i];
            end
            act_q     <= act_n;
            pend_q    <= pend_n;
            done      <= done_n;
            err_multi <= err_multi | gnt_multi;
            err_spur  <= err_spur | (|(GNT & ~REQ));
        end
    end

endmodule
